// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and default width for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int MDU_XLEN = 32;

    typedef enum logic [1:0] {
        MDU_MUL   = 2'b00,
        MDU_MULHU = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_REMU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one restoring-divide iteration; shifts in the next dividend bit and trial-subtracts the divisor.
module mdu_div_step
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            in_bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // One extra bit keeps the shifted remainder exact; diff's MSB is the borrow/sign.
    always_comb begin
        shifted = {rem_i, in_bit_i};
        diff    = shifted - {1'b0, divisor_i};
        rem_o   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        q_bit_o = ~diff[XLEN];
    end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative unsigned MUL/MULHU/DIVU/REMU unit that stalls the pipeline front until its result is ready.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            kill,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            div_zero
);

    localparam int CW = $clog2(XLEN);

    state_e          state_q;
    mdu_op_e         op_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, result_q, rem_n, calc_res;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]   mul_sum;
    logic            q_bit, busy_q, done_q, div_zero_q;

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i     (acc_q[2*XLEN-1:XLEN]),
        .in_bit_i  (a_q[XLEN-1]),
        .divisor_i (b_q),
        .rem_o     (rem_n),
        .q_bit_o   (q_bit)
    );

    // acc holds {hi, lo} = product for multiply, {remainder, quotient} for divide;
    // so the odd ops (MULHU/REMU) pick the upper word.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
        acc_d    = op_q[1] ? {rem_n, acc_q[XLEN-2:0], q_bit} : {mul_sum, acc_q[XLEN-1:1]};
        a_d      = op_q[1] ? {a_q[XLEN-2:0], 1'b0} : a_q;
        b_d      = op_q[1] ? b_q : {1'b0, b_q[XLEN-1:1]};
        calc_res = op_q[0] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
        stall    = (state_q == S_IDLE && start && !kill) || state_q == S_CALC;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            if (kill) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        op_q   <= mdu_op_e'(op);
                        a_q    <= operand_a;
                        b_q    <= operand_b;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (op[1] && operand_b == '0) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            div_zero_q <= 1'b1;
                            result_q   <= op[0] ? operand_a : '1;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                    S_CALC: begin
                        acc_q <= acc_d;
                        a_q   <= a_d;
                        b_q   <= b_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(XLEN - 1)) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= calc_res;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed and random checks of mdu_sequencer against a plain-arithmetic reference.
module tb_mdu_sequencer;

    logic        clock = 1'b0;
    logic        reset, start, kill;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        stall, busy, done, div_zero;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_res;

    mdu_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .kill(kill),
        .stall(stall), .busy(busy), .done(done), .result(result), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = 64'(x) * 64'(y);
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int k, st, exp_k;
        logic dz;
        dz    = o[1] && (y == 0);
        exp_k = dz ? 0 : 32;
        @(negedge clock);
        start = 1'b1; op = o; operand_a = x; operand_b = y;
        #1;
        st = stall ? 1 : 0;
        tick();
        start = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            if (stall) st++;
            tick();
            k++;
        end
        check({tag, " latency"}, 64'(k), 64'(exp_k));
        check({tag, " stall_cycles"}, 64'(st), 64'(exp_k + 1));
        check({tag, " result"}, 64'(result), 64'(ref_result(o, x, y)));
        check({tag, " div_zero"}, 64'(div_zero), 64'(dz));
        check({tag, " stall_in_done"}, 64'(stall), 64'(0));
        last_res = ref_result(o, x, y);
        tick();
        check({tag, " done_pulse"}, 64'(done), 64'(0));
        check({tag, " idle_after"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int nd;
        reset = 1'b1; start = 1'b0; kill = 1'b0; op = 2'd0; operand_a = '0; operand_b = '0;
        repeat (2) tick();
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset result", 64'(result), 64'(0));
        check("reset div_zero", 64'(div_zero), 64'(0));
        check("reset stall", 64'(stall), 64'(0));
        reset = 1'b0;
        tick();

        run_op("mul 7x6", 2'd0, 32'd7, 32'd6);
        run_op("mulhu ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mul ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("divu 100/7", 2'd2, 32'd100, 32'd7);
        run_op("remu 100/7", 2'd3, 32'd100, 32'd7);
        run_op("divu msb/1", 2'd2, 32'h8000_0000, 32'd1);
        run_op("divu 5/0", 2'd2, 32'd5, 32'd0);
        run_op("remu 5/0", 2'd3, 32'd5, 32'd0);

        // kill mid-multiply with a stray start while busy
        @(negedge clock);
        start = 1'b1; op = 2'd0; operand_a = 32'd9; operand_b = 32'd9;
        tick();
        start = 1'b0;
        repeat (5) tick();
        start = 1'b1; op = 2'd2; operand_a = 32'd1; operand_b = 32'd0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("kill busy_before", 64'(busy), 64'(1));
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill busy", 64'(busy), 64'(0));
        check("kill done", 64'(done), 64'(0));
        check("kill stall", 64'(stall), 64'(0));
        check("kill result", 64'(result), 64'(last_res));
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) nd++;
            tick();
        end
        check("kill no_activity", 64'(nd), 64'(0));
        check("kill result_hold", 64'(result), 64'(last_res));

        // kill wins over start in idle
        start = 1'b1; kill = 1'b1; op = 2'd2; operand_a = 32'd3; operand_b = 32'd0;
        #1;
        check("kill+start stall", 64'(stall), 64'(0));
        tick();
        start = 1'b0; kill = 1'b0;
        check("kill+start busy", 64'(busy), 64'(0));
        check("kill+start done", 64'(done), 64'(0));
        check("kill+start result", 64'(result), 64'(last_res));

        // reset mid-divide
        @(negedge clock);
        start = 1'b1; op = 2'd2; operand_a = 32'd1000; operand_b = 32'd3;
        tick();
        start = 1'b0;
        repeat (20) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid busy", 64'(busy), 64'(0));
        check("rst_mid stall", 64'(stall), 64'(0));
        check("rst_mid result", 64'(result), 64'(0));
        check("rst_mid done", 64'(done), 64'(0));
        run_op("mul 3x5", 2'd0, 32'd3, 32'd5);

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300));
            run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative multiply/divide sequencer for the EX stage of the pipelined core. It accepts one unsigned multiply or divide request from the ID/EX register. It runs a 32-iteration shift-add multiply or restoring-divide datapath over many cycles, and holds the front of the pipeline through the stall path until the result is ready. The result is then handed to EX/MEM through the normal execution-unit result mux.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; iteration count equals `XLEN`.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clock`.
- `start`  in  1  request valid from ID/EX (execution-unit enable with an MDU opcode).
- `op`  in  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
- `operand_a`  in  XLEN  forwarded rs1 value (multiplicand / dividend).
- `operand_b`  in  XLEN  forwarded rs2 value (multiplier / divisor).
- `kill`  in  1  pipeline flush; aborts any operation in flight.
- `stall`  out  1  hold PC, IF/ID and ID/EX.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  XLEN  selected product word, quotient or remainder.
- `div_zero`  out  1  set with `done` when a DIVU/REMU divisor was 0.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - `start`=1, `kill`=0: latch `op`, `operand_a`, `operand_b`; clear the 64-bit accumulator; clear the 5-bit counter.
  - Then go to CALC. Exception: a DIVU/REMU with `operand_b`==0 goes directly to DONE.
- **CALC**, one iteration per edge:
  - MUL/MULHU: if the multiplier LSB is 1, add the multiplicand to the upper half. Shift the {carry, accumulator} pair right by 1.
  - DIVU/REMU: shift the {remainder, quotient} pair left by 1. Trial-subtract the divisor from the remainder using XLEN+1 bits. If the result is non-negative, keep it and set the quotient LSB.
  - Counter increments each edge. At count==XLEN-1, go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle. Next edge goes to IDLE.
  - `result` is loaded into the output register on the edge entering DONE. It then holds its value until the next DONE entry.
- Result select:
  - MUL → product[XLEN-1:0]
  - MULHU → product[2·XLEN-1:XLEN]
  - DIVU → quotient
  - REMU → remainder
- Divide by zero follows RISC-V semantics: quotient = all ones, remainder = `operand_a`, `div_zero`=1 with `done`.
- `start` while not IDLE is ignored; operands are not re-sampled.
- `kill` in any state: go to IDLE on the next edge. No `done` is produced and `result` is unchanged.
  - `kill` together with `start` in IDLE: `kill` wins and nothing is latched.
- `reset` in any state: state=IDLE, counter=0, `result`=0, `done`=0, `div_zero`=0.

## Timing
- `start` sampled at edge N. Iterations run on edges N+1…N+XLEN. DONE is entered at edge N+XLEN, and `done` is high in the following cycle. That is 33 cycles total for XLEN=32.
- Divide by zero: DONE is entered at edge N+1, so `done` is high in the cycle after the start edge.
- `stall` = (IDLE & `start` & ~`kill`) | CALC. It is combinational, so the instruction is held in ID/EX from the request cycle onward.
- `stall` is low in DONE, so the pipeline advances and EX/MEM captures `result` on that edge.
- `busy` is registered-state-only. It is high in CALC and DONE.
- All outputs except `stall` come directly from registers.

## Structure
- Shared package `mdu_pkg`: `op` encodings (MDU_MUL, MDU_MULHU, MDU_DIVU, MDU_REMU), the state enum (S_IDLE, S_CALC, S_DONE), and an XLEN default constant.
- One sub-module is natural: `mdu_div_step`. It is the combinational trial-subtract/shift for a single divide iteration, and it keeps the restoring compare width (XLEN+1) isolated.
- The multiply step stays inline.

## Test plan
- MUL: a=7, b=6, start at edge N. Required: `stall` high for 33 cycles, `done` in the cycle after edge N+32, `result`=42, `div_zero`=0.
- MULHU: a=b=0xFFFFFFFF. Required: `result`=0xFFFFFFFE. Repeat with MUL on the same operands: `result`=0x00000001.
- DIVU/REMU: a=100, b=7. Required: DIVU `result`=14, REMU `result`=2. Also a=0x80000000, b=1: DIVU `result`=0x80000000.
- Divide by zero: DIVU a=5, b=0. Required: `done` in the cycle after the start edge, `result`=0xFFFFFFFF, `div_zero`=1. REMU with the same operands: `result`=5.
- `kill` asserted at iteration 10 of a MUL, with `start` also re-asserted while busy. Required: IDLE the next cycle, no `done` pulse, `result` keeps its previous value, and the second `start` is not captured.
- `reset` asserted mid-DIVU at iteration 20. Required: next cycle `busy`=0, `stall`=0, `result`=0. A new MUL 3×5 issued afterward returns 15 with normal latency.
